// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM bus arbiter for the read, write and auto-refresh sequencers
module sdram_arbiter #(
    parameter int REFRESH_PERIOD = 390,
    parameter int TIMEOUT        = 255,
    parameter int GAP_CYCLES     = 2
) (
    input  logic iclk,
    input  logic ireset,
    input  logic iinit_fin,
    input  logic iwr_req,
    input  logic ird_req,
    output logic owr_done,
    output logic ord_done,
    output logic owr_enb,
    output logic ord_enb,
    output logic oref_enb,
    output logic owr_start,
    output logic ord_start,
    output logic oref_start,
    input  logic iwr_fin,
    input  logic ird_fin,
    input  logic iref_fin,
    output logic obusy,
    output logic oerr,
    output logic oref_overrun
);

    localparam int RW = $clog2(REFRESH_PERIOD);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_PERIOD - 1);
    localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        SEL_WR,
        SEL_RD,
        SEL_REF
    } sel_t;

    state_t          state, state_n;
    sel_t            winner, winner_n;
    logic            last_rd;
    logic [7:0]      to_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [RW-1:0]   ref_cnt;
    logic            ref_pending;
    logic            ref_wrap;
    logic            win_fin;
    logic            busy_fin;
    logic            busy_timeout;
    logic            enb_keep;

    always_comb begin
        win_fin = 1'b0;
        case (winner)
            SEL_WR:  win_fin = iwr_fin;
            SEL_RD:  win_fin = ird_fin;
            SEL_REF: win_fin = iref_fin;
            default: win_fin = 1'b0;
        endcase
    end

    always_comb begin
        state_n      = state;
        winner_n     = winner;
        busy_fin     = 1'b0;
        busy_timeout = 1'b0;
        case (state)
            S_WAIT_INIT: begin
                if (iinit_fin) state_n = S_IDLE;
            end
            S_IDLE: begin
                // Refresh outranks data; read/write alternate when both are asking.
                if (ref_pending) begin
                    winner_n = SEL_REF;
                    state_n  = S_GRANT;
                end else if (iwr_req && ird_req) begin
                    winner_n = last_rd ? SEL_WR : SEL_RD;
                    state_n  = S_GRANT;
                end else if (iwr_req) begin
                    winner_n = SEL_WR;
                    state_n  = S_GRANT;
                end else if (ird_req) begin
                    winner_n = SEL_RD;
                    state_n  = S_GRANT;
                end
            end
            S_GRANT: begin
                state_n = S_BUSY;
            end
            S_BUSY: begin
                if (win_fin) begin
                    busy_fin = 1'b1;
                    state_n  = S_GAP;
                end else if (to_cnt == TO_LAST) begin
                    busy_timeout = 1'b1;
                    state_n      = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = S_IDLE;
            end
            default: begin
                state_n = S_WAIT_INIT;
            end
        endcase
    end

    assign enb_keep = (state == S_GRANT) ||
                      ((state == S_BUSY) && !busy_fin && !busy_timeout);
    assign ref_wrap = (state != S_WAIT_INIT) && (ref_cnt == REF_LAST);

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state   <= S_WAIT_INIT;
            winner  <= SEL_WR;
            last_rd <= 1'b0;
            to_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            winner  <= winner_n;
            if (state == S_GRANT && winner != SEL_REF) last_rd <= (winner == SEL_RD);
            to_cnt  <= (state == S_BUSY) ? to_cnt + 8'd1 : 8'd0;
            gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            ref_cnt      <= '0;
            ref_pending  <= 1'b0;
            oref_overrun <= 1'b0;
        end else begin
            if (state == S_WAIT_INIT || ref_wrap) ref_cnt <= '0;
            else                                  ref_cnt <= ref_cnt + RW'(1);
            // A wrap coinciding with a refresh grant re-arms pending for the new period.
            if (ref_wrap) begin
                ref_pending <= 1'b1;
                if (ref_pending) oref_overrun <= 1'b1;
            end else if (state == S_GRANT && winner == SEL_REF) begin
                ref_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            owr_enb    <= 1'b0;
            ord_enb    <= 1'b0;
            oref_enb   <= 1'b0;
            owr_start  <= 1'b0;
            ord_start  <= 1'b0;
            oref_start <= 1'b0;
            owr_done   <= 1'b0;
            ord_done   <= 1'b0;
            obusy      <= 1'b1;
            oerr       <= 1'b0;
        end else begin
            owr_enb    <= enb_keep && (winner == SEL_WR);
            ord_enb    <= enb_keep && (winner == SEL_RD);
            oref_enb   <= enb_keep && (winner == SEL_REF);
            owr_start  <= (state == S_GRANT) && (winner == SEL_WR);
            ord_start  <= (state == S_GRANT) && (winner == SEL_RD);
            oref_start <= (state == S_GRANT) && (winner == SEL_REF);
            owr_done   <= busy_fin && (winner == SEL_WR);
            ord_done   <= busy_fin && (winner == SEL_RD);
            obusy      <= (state_n != S_IDLE);
            if (busy_timeout) oerr <= 1'b1;
        end
    end

    enb_onehot: assert property (@(posedge iclk) disable iff (ireset)
        $onehot0({owr_enb, ord_enb, oref_enb}));

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

    logic iclk = 1'b0;
    logic ireset = 1'b1;
    logic iinit_fin = 1'b0;
    logic iwr_req = 1'b0;
    logic ird_req = 1'b0;
    logic iwr_fin = 1'b0;
    logic ird_fin = 1'b0;
    logic iref_fin = 1'b0;
    logic owr_done, ord_done, owr_enb, ord_enb, oref_enb;
    logic owr_start, ord_start, oref_start, obusy, oerr, oref_overrun;

    sdram_arbiter dut (
        .iclk(iclk), .ireset(ireset), .iinit_fin(iinit_fin),
        .iwr_req(iwr_req), .ird_req(ird_req),
        .owr_done(owr_done), .ord_done(ord_done),
        .owr_enb(owr_enb), .ord_enb(ord_enb), .oref_enb(oref_enb),
        .owr_start(owr_start), .ord_start(ord_start), .oref_start(oref_start),
        .iwr_fin(iwr_fin), .ird_fin(ird_fin), .iref_fin(iref_fin),
        .obusy(obusy), .oerr(oerr), .oref_overrun(oref_overrun)
    );

    always #5 iclk = ~iclk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // monitor: 1=WR start, 2=RD start, 3=REF start
    int cyc = 0;
    int log_q[$];
    int ref_t[$];
    int wr_enb_cnt = 0, rd_enb_cnt = 0;
    int wr_done_cnt = 0, rd_done_cnt = 0;
    int excl_bad = 0;

    always @(posedge iclk) cyc <= cyc + 1;

    always @(negedge iclk) begin
        if (owr_enb) wr_enb_cnt++;
        if (ord_enb) rd_enb_cnt++;
        if (owr_done) wr_done_cnt++;
        if (ord_done) rd_done_cnt++;
        if (owr_start) log_q.push_back(1);
        if (ord_start) log_q.push_back(2);
        if (oref_start) begin
            log_q.push_back(3);
            ref_t.push_back(cyc);
        end
        if (int'(owr_enb) + int'(ord_enb) + int'(oref_enb) > 1) excl_bad++;
    end

    // sequencer models: fin pulses <delay> cycles after the start cycle
    int wr_delay = 8;
    int rd_delay = 5;
    bit rd_fin_en = 1'b1;
    bit wr_act = 0, rd_act = 0, ref_act = 0;
    int wr_age = 0, rd_age = 0, ref_age = 0;

    always @(negedge iclk) begin
        if (ireset) begin
            wr_act = 0; rd_act = 0; ref_act = 0;
            iwr_fin = 0; ird_fin = 0; iref_fin = 0;
        end else begin
            if (owr_start) begin wr_act = 1; wr_age = 0; end else if (wr_act) wr_age++;
            iwr_fin = wr_act && (wr_age == wr_delay);
            if (iwr_fin) wr_act = 0;
            if (ord_start) begin rd_act = 1; rd_age = 0; end else if (rd_act) rd_age++;
            ird_fin = rd_act && rd_fin_en && (rd_age == rd_delay);
            if (ird_fin) rd_act = 0;
            if (oref_start) begin ref_act = 1; ref_age = 0; end else if (ref_act) ref_age++;
            iref_fin = ref_act && (ref_age == 4);
            if (iref_fin) ref_act = 0;
        end
    end

    function automatic bit sig(input int code);
        case (code)
            0: return owr_start;
            1: return ord_start;
            2: return oref_start;
            3: return owr_done;
            4: return ord_done;
            5: return !obusy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_on(input string tag, input int code, input int budget, output int n);
        n = 0;
        do begin
            @(negedge iclk);
            n++;
        end while (!sig(code) && n < budget);
        if (!sig(code)) chk(tag, 0, 1);
    endtask

    task automatic do_reset(input int init_delay);
        ireset = 1'b1;
        iinit_fin = 1'b0;
        iwr_req = 1'b0;
        ird_req = 1'b0;
        repeat (3) @(negedge iclk);
        ireset = 1'b0;
        repeat (init_delay) @(negedge iclk);
        iinit_fin = 1'b1;
    endtask

    initial begin
        int n, k, n0, w0, r0, d0, rd0, hi;
        int ord[4];

        // 1: reset values, init wait, periodic refresh
        repeat (3) @(negedge iclk);
        chk("rst_enb", int'({owr_enb, ord_enb, oref_enb}), 0);
        chk("rst_start", int'({owr_start, ord_start, oref_start}), 0);
        chk("rst_done", int'({owr_done, ord_done}), 0);
        chk("rst_busy", int'(obusy), 1);
        chk("rst_err", int'({oerr, oref_overrun}), 0);
        ireset = 1'b0;
        repeat (5) @(negedge iclk);
        chk("winit_busy", int'(obusy), 1);
        n0 = ref_t.size();
        w0 = wr_enb_cnt;
        r0 = rd_enb_cnt;
        iinit_fin = 1'b1;
        k = cyc;
        n = 0;
        while (ref_t.size() < n0 + 3 && n < 1400) begin
            @(negedge iclk);
            n++;
        end
        repeat (2) @(negedge iclk);
        if (ref_t.size() < n0 + 3) begin
            chk("t1_ref_count", ref_t.size() - n0, 3);
        end else begin
            chk("t1_first_ref", ref_t[n0] - k, 393);
            chk("t1_period_a", ref_t[n0+1] - ref_t[n0], 390);
            chk("t1_period_b", ref_t[n0+2] - ref_t[n0+1], 390);
        end
        chk("t1_wr_enb", wr_enb_cnt - w0, 0);
        chk("t1_rd_enb", rd_enb_cnt - r0, 0);
        chk("t1_overrun", int'(oref_overrun), 0);

        // 2: lone write, fin 8 cycles after start
        do_reset(2);
        wr_delay = 8;
        w0 = wr_enb_cnt;
        r0 = rd_enb_cnt;
        d0 = wr_done_cnt;
        iwr_req = 1'b1;
        wait_on("t2_done_wait", 3, 50, n);
        iwr_req = 1'b0;
        wait_on("t2_idle_wait", 5, 20, n);
        chk("t2_idle_lat", n, 2);
        repeat (3) @(negedge iclk);
        chk("t2_enb_cycles", wr_enb_cnt - w0, 9);
        chk("t2_done_cnt", wr_done_cnt - d0, 1);
        chk("t2_rd_enb", rd_enb_cnt - r0, 0);

        // 3: both requesting -> RD, WR, RD, WR
        do_reset(2);
        wr_delay = 3;
        iwr_req = 1'b1;
        ird_req = 1'b1;
        k = 0;
        n = 0;
        while (k < 4 && n < 300) begin
            @(negedge iclk);
            n++;
            if (owr_start) begin ord[k] = 1; k++; end
            else if (ord_start) begin ord[k] = 2; k++; end
        end
        iwr_req = 1'b0;
        ird_req = 1'b0;
        chk("t3_grants", k, 4);
        if (k == 4) begin
            chk("t3_g0", ord[0], 2);
            chk("t3_g1", ord[1], 1);
            chk("t3_g2", ord[2], 2);
            chk("t3_g3", ord[3], 1);
        end
        repeat (30) @(negedge iclk);

        // 4: refresh wraps during a long write, beats the waiting read
        wr_delay = 40;
        wait_on("t4_ref_wait", 2, 500, n);
        @(negedge iclk);
        n0 = log_q.size();
        repeat (369) @(negedge iclk);
        iwr_req = 1'b1;
        repeat (10) @(negedge iclk);
        ird_req = 1'b1;
        wait_on("t4_wr_done", 3, 100, n);
        iwr_req = 1'b0;
        wait_on("t4_rd_done", 4, 100, n);
        ird_req = 1'b0;
        repeat (4) @(negedge iclk);
        chk("t4_entries", log_q.size() - n0, 3);
        if (log_q.size() - n0 == 3) begin
            chk("t4_first", log_q[n0], 1);
            chk("t4_second", log_q[n0+1], 3);
            chk("t4_third", log_q[n0+2], 2);
        end
        chk("t4_overrun", int'(oref_overrun), 0);

        // 5: read never finishes -> timeout after 255 busy cycles
        do_reset(2);
        rd_fin_en = 1'b0;
        @(negedge iclk);
        chk("t5_err_pre", int'(oerr), 0);
        r0 = rd_enb_cnt;
        rd0 = rd_done_cnt;
        ird_req = 1'b1;
        wait_on("t5_start", 1, 20, n);
        ird_req = 1'b0;
        repeat (270) @(negedge iclk);
        chk("t5_enb_cycles", rd_enb_cnt - r0, 255);
        chk("t5_err", int'(oerr), 1);
        chk("t5_no_done", rd_done_cnt - rd0, 0);
        chk("t5_enb_low", int'(ord_enb), 0);
        rd_fin_en = 1'b1;

        // 6: reset while a write is busy
        wr_delay = 40;
        d0 = wr_done_cnt;
        iwr_req = 1'b1;
        wait_on("t6_start", 0, 40, n);
        repeat (5) @(negedge iclk);
        chk("t6_enb_busy", int'(owr_enb), 1);
        #2;
        ireset = 1'b1;
        iinit_fin = 1'b0;
        #1;
        chk("t6_enb_async", int'(owr_enb), 0);
        chk("t6_busy_rst", int'(obusy), 1);
        chk("t6_err_clr", int'(oerr), 0);
        @(negedge iclk);
        ireset = 1'b0;
        @(negedge iclk);
        n0 = log_q.size();
        hi = 0;
        repeat (20) begin
            @(negedge iclk);
            if (obusy && !owr_enb) hi++;
        end
        chk("t6_wait_init", hi, 20);
        chk("t6_no_grant", log_q.size() - n0, 0);
        iinit_fin = 1'b1;
        wait_on("t6_done", 3, 100, n);
        iwr_req = 1'b0;
        repeat (4) @(negedge iclk);
        chk("t6_done_cnt", wr_done_cnt - d0, 1);

        chk("excl_enb", excl_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
